// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: op-code enum, RV32I opcode/funct7 constants and
// small decode helpers used by the issue stage and the ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Base-variant op selected by funct3 (funct7 alternates resolved by caller)
    function automatic alu_op_e f3_to_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: upstream instruction/operand handshake, flush, and
// the registered ALU operand bundle handed to execute.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [OP_WIDTH-1:0]   ALUControl;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  illegal;

    // Environment side: feeds instructions, consumes the bundle
    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, ALUControl, SrcA, SrcB, rd, reg_write, illegal
    );

    // Issue stage side
    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, ALUControl, SrcA, SrcB, rd, reg_write, illegal
    );
endinterface

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC producing the
// unregistered ALU bundle. Anything else is flagged illegal with zero operands.
module alu_control_decoder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output alu_op_e               alu_op,
    output logic [DATA_WIDTH-1:0] src_a,
    output logic [DATA_WIDTH-1:0] src_b,
    output logic [4:0]            rd,
    output logic                  reg_write,
    output logic                  illegal
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = DATA_WIDTH'($signed(instr[31:20]));
    assign imm_u  = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
    assign rd     = instr[11:7];

    // Opcode/funct decode, shift-amount masking and illegal squashing
    always_comb begin
        alu_op  = ALU_ADD;
        src_a   = '0;
        src_b   = '0;
        illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                src_a  = rs1_data;
                src_b  = rs2_data;
                alu_op = f3_to_op(funct3);
                if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      alu_op = ALU_SUB;
                    else if (funct3 == 3'b101) alu_op = ALU_SRA;
                    else                       illegal = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                src_a  = rs1_data;
                src_b  = imm_i;
                alu_op = f3_to_op(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE) illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                src_b = imm_u;
            end
            OPC_AUIPC: begin
                src_a = pc;
                src_b = imm_u;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        // ALU shifts by the full SrcB, so only the 5-bit amount may survive
        if (is_shift(alu_op)) begin
            src_b = DATA_WIDTH'(src_b[4:0]);
        end

        if (illegal) begin
            alu_op = ALU_ADD;
            src_a  = '0;
            src_b  = '0;
        end
    end

    assign reg_write = !illegal && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: valid/ready handshake on both sides around a single
// output register holding the decoded ALU bundle. Flush drops the held and
// any incoming instruction.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   bus
);

    alu_op_e               dec_op;
    logic [DATA_WIDTH-1:0] dec_src_a;
    logic [DATA_WIDTH-1:0] dec_src_b;
    logic [4:0]            dec_rd;
    logic                  dec_reg_write;
    logic                  dec_illegal;

    logic                  valid_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] src_a_q;
    logic [DATA_WIDTH-1:0] src_b_q;
    logic [4:0]            rd_q;
    logic                  reg_write_q;
    logic                  illegal_q;

    logic                  ready;
    logic                  accept;

    alu_control_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decoder (
        .instr     (bus.instr),
        .pc        (bus.pc),
        .rs1_data  (bus.rs1_data),
        .rs2_data  (bus.rs2_data),
        .alu_op    (dec_op),
        .src_a     (dec_src_a),
        .src_b     (dec_src_b),
        .rd        (dec_rd),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

    // Ready whenever the slot is empty or being drained, unless flushing
    always_comb begin
        ready  = !bus.flush && (!valid_q || bus.out_ready);
        accept = bus.in_valid && ready;
    end

    // Output register: flush clears valid, accept reloads, drain empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            op_q        <= OP_WIDTH'(dec_op);
            src_a_q     <= dec_src_a;
            src_b_q     <= dec_src_b;
            rd_q        <= dec_rd;
            reg_write_q <= dec_reg_write;
            illegal_q   <= dec_illegal;
        end else if (bus.out_ready) begin
            valid_q     <= 1'b0;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.ALUControl = op_q;
    assign bus.SrcA       = src_a_q;
    assign bus.SrcB       = src_b_q;
    assign bus.rd         = rd_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized
// traffic compared against a cycle-level reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    logic clk;
    logic rst;

    alu_issue_stage_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();

    alu_issue_stage #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [3:0] f3op [8];
    logic       exp_valid;
    bundle_t    exp_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural decode straight from the ISA field rules
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                           input logic [31:0] a, input logic [31:0] b);
        bundle_t     r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        r     = '0;
        r.rd  = ins[11:7];
        r.ill = 1'b1;
        if (opc == 7'h33) begin
            r.a = a;
            r.b = b;
            if (f7 == 7'h00) begin
                r.ill = 1'b0;
                r.op  = f3op[f3];
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                r.ill = 1'b0;
                r.op  = (f3 == 3'd0) ? 4'd1 : 4'd7;
            end
        end else if (opc == 7'h13) begin
            r.a   = a;
            r.b   = imm;
            r.op  = f3op[f3];
            r.ill = 1'b0;
            if (f3 == 3'd1 && f7 != 7'h00) r.ill = 1'b1;
            if (f3 == 3'd5) begin
                if (f7 == 7'h20)      r.op  = 4'd7;
                else if (f7 != 7'h00) r.ill = 1'b1;
            end
        end else if (opc == 7'h37) begin
            r.ill = 1'b0;
            r.b   = {ins[31:12], 12'h000};
        end else if (opc == 7'h17) begin
            r.ill = 1'b0;
            r.a   = pcv;
            r.b   = {ins[31:12], 12'h000};
        end
        if (r.op == 4'd2 || r.op == 4'd6 || r.op == 4'd7) r.b = r.b & 32'h1F;
        if (r.ill) begin
            r.op = 4'd0;
            r.a  = 32'd0;
            r.b  = 32'd0;
        end
        r.we = !r.ill && (r.rd != 5'd0);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic ordy);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc        = pcv;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    // One clock: check in_ready, advance model at the edge, check outputs
    task automatic step();
        logic exp_rdy;
        #1;
        exp_rdy = !bus.flush && (!exp_valid || bus.out_ready);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (bus.flush) begin
            exp_valid = 1'b0;
        end else if (bus.in_valid && exp_rdy) begin
            exp_b     = ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
            exp_valid = 1'b1;
        end else if (bus.out_ready) begin
            exp_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("ALUControl", 32'(bus.ALUControl), 32'(exp_b.op));
            check("SrcA", bus.SrcA, exp_b.a);
            check("SrcB", bus.SrcB, exp_b.b);
            check("rd", 32'(bus.rd), 32'(exp_b.rd));
            check("reg_write", 32'(bus.reg_write), 32'(exp_b.we));
            check("illegal", 32'(bus.illegal), 32'(exp_b.ill));
        end
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_op"}, 32'(bus.ALUControl), 32'd0);
        check({tag, "_srca"}, bus.SrcA, 32'd0);
        check({tag, "_srcb"}, bus.SrcB, 32'd0);
        check({tag, "_rd"}, 32'(bus.rd), 32'd0);
        check({tag, "_we"}, 32'(bus.reg_write), 32'd0);
        check({tag, "_ill"}, 32'(bus.illegal), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int unsigned sel;
        ins = $urandom;
        sel = $urandom_range(0, 6);
        case (sel)
            0, 1: ins[6:0] = 7'h33;
            2, 3: ins[6:0] = 7'h13;
            4:    ins[6:0] = 7'h37;
            5:    ins[6:0] = 7'h17;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h00;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        f3op[0] = 4'd0; f3op[1] = 4'd2; f3op[2] = 4'd3; f3op[3] = 4'd4;
        f3op[4] = 4'd5; f3op[5] = 4'd6; f3op[6] = 4'd8; f3op[7] = 4'd9;
        n_checks  = 0;
        n_fail    = 0;
        exp_valid = 1'b0;
        exp_b     = '0;

        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // ADD x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'd0, 32'd5, 32'd7, 1'b0, 1'b1);
        step();
        check("add_op", 32'(bus.ALUControl), 32'd0);
        check("add_srca", bus.SrcA, 32'd5);
        check("add_srcb", bus.SrcB, 32'd7);
        check("add_rd", 32'(bus.rd), 32'd3);
        check("add_we", 32'(bus.reg_write), 32'd1);

        // SRAI x5,x6,4
        drive(1'b1, 32'h40435293, 32'd0, 32'hF0000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        step();
        check("srai_op", 32'(bus.ALUControl), 32'd7);
        check("srai_srcb", bus.SrcB, 32'd4);

        // SRA x5,x6,x7 with rs2=0x124
        drive(1'b1, 32'h407352B3, 32'd0, 32'hF0000000, 32'h00000124, 1'b0, 1'b1);
        step();
        check("sra_op", 32'(bus.ALUControl), 32'd7);
        check("sra_srcb", bus.SrcB, 32'd4);

        // Backpressure: AND x9,x1,x2 held while XOR x10,x1,x2 waits
        drive(1'b1, 32'h0020F4B3, 32'd0, 32'h1111, 32'h2222, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0020C533, 32'd0, 32'h3333, 32'h4444, 1'b0, 1'b0);
            step();
            check("hold_srca", bus.SrcA, 32'h1111);
            check("hold_rd", 32'(bus.rd), 32'd9);
        end
        drive(1'b1, 32'h0020C533, 32'd0, 32'h3333, 32'h4444, 1'b0, 1'b1);
        step();
        check("release_valid", 32'(bus.out_valid), 32'd1);
        check("release_rd", 32'(bus.rd), 32'd10);
        check("release_op", 32'(bus.ALUControl), 32'd5);

        // Flush with simultaneous input: dropped instruction never appears
        drive(1'b1, 32'h00208633, 32'd0, 32'h5555, 32'h6666, 1'b1, 1'b1);
        step();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 32'h00208633, 32'd0, 32'h5555, 32'h6666, 1'b0, 1'b1);
        step();
        check("flush_gone", 32'(bus.out_valid), 32'd0);

        // Illegal: load opcode, then OP with funct7=0000001
        drive(1'b1, 32'h0000A183, 32'd0, 32'h77, 32'h88, 1'b0, 1'b1);
        step();
        check("load_ill", 32'(bus.illegal), 32'd1);
        check("load_we", 32'(bus.reg_write), 32'd0);
        check("load_op", 32'(bus.ALUControl), 32'd0);
        drive(1'b1, 32'h022081B3, 32'd0, 32'h77, 32'h88, 1'b0, 1'b1);
        step();
        check("mul_ill", 32'(bus.illegal), 32'd1);
        check("mul_we", 32'(bus.reg_write), 32'd0);
        check("mul_srca", bus.SrcA, 32'd0);

        // AUIPC x1,0x12345
        drive(1'b1, 32'h12345097, 32'h100, 32'h9, 32'h9, 1'b0, 1'b1);
        step();
        check("auipc_srca", bus.SrcA, 32'h100);
        check("auipc_srcb", bus.SrcB, 32'h12345000);
        check("auipc_op", 32'(bus.ALUControl), 32'd0);

        // Asynchronous reset mid-stream with a held bundle
        drive(1'b1, 32'h002081B3, 32'd0, 32'd5, 32'd7, 1'b0, 1'b0);
        step();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        exp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
